// File: rtl/pool_array_2x2_if.sv
// Activation-in / pooled-out stream bundle of pool_array_2x2.
// slave: the pooling block. master: producer of act_*, consumer of pool_*.
interface pool_array_2x2_if #(
  parameter int CH_NUM        = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10
);
  logic                              act_valid_i;
  logic                              act_last_i;
  logic [CH_NUM-1:0][DATA_WIDTH-1:0] act_result_i;
  logic                              pool_valid_o;
  logic                              pool_last_o;
  logic [CH_NUM-1:0][DATA_WIDTH-1:0] pool_result_o;
  logic [ADDRESS_WIDTH-1:0]          pool_result_address_o;

  modport slave (
    input  act_valid_i,
    input  act_last_i,
    input  act_result_i,
    output pool_valid_o,
    output pool_last_o,
    output pool_result_o,
    output pool_result_address_o
  );

  modport master (
    output act_valid_i,
    output act_last_i,
    output act_result_i,
    input  pool_valid_o,
    input  pool_last_o,
    input  pool_result_o,
    input  pool_result_address_o
  );
endinterface

// File: rtl/pool_array_2x2.sv
// Multi-channel 2x2 stride-2 max/avg pooling of a raster activation stream.
// Ports: clk, rst (async low); cfg_* start/width/mode/base; busy_o, err_o;
// io (slave): act_valid/last/result in, pool_valid/last/result/address out.
// POOL_AVG_EN defined: average mode available; undefined: max-only.
module pool_array_2x2 #(
  parameter int CH_NUM        = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10,
  parameter int MAX_FM_WIDTH  = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_start_i,
  input  logic [$clog2(MAX_FM_WIDTH+1)-1:0]  cfg_fm_width_i,
  input  logic                               cfg_mode_i,
  input  logic [ADDRESS_WIDTH-1:0]           cfg_base_addr_i,
  output logic                               busy_o,
  output logic                               err_o,
  pool_array_2x2_if.slave                    io
);
  localparam int WW       = $clog2(MAX_FM_WIDTH+1);
  localparam int LB_DEPTH = MAX_FM_WIDTH / 2;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
`ifdef POOL_AVG_EN
  localparam int HW       = DATA_WIDTH + 1;
  localparam int SW       = DATA_WIDTH + 2;
`else
  localparam int HW       = DATA_WIDTH;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t                            state_q;
  logic [WW-1:0]                     width_q;
  logic [WW-1:0]                     col_q;
  logic                              row_q;
  logic [ADDRESS_WIDTH-1:0]          addr_q;
  logic [CH_NUM-1:0][DATA_WIDTH-1:0] hold_q;
  logic [CH_NUM-1:0][HW-1:0]         lb_q [LB_DEPTH];

  logic [CH_NUM-1:0][HW-1:0]         lb_rd;
  logic [CH_NUM-1:0][HW-1:0]         h_c;
  logic [CH_NUM-1:0][DATA_WIDTH-1:0] p_c;
  logic [LBW-1:0]                    lb_idx;
  logic                              beat;
  logic                              col_odd;
  logic                              row_end;
  logic                              cfg_ok;

`ifdef POOL_AVG_EN
  logic                              mode_q;
  logic [CH_NUM-1:0][SW-1:0]         s_c;
`else
  logic                              unused_mode;
  assign unused_mode = cfg_mode_i;
`endif

  function automatic logic [DATA_WIDTH-1:0] max2(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign beat    = (state_q == RUN) && io.act_valid_i;
  assign col_odd = col_q[0];
  assign row_end = (col_q == width_q - WW'(1));
  assign cfg_ok  = (cfg_fm_width_i >= WW'(2)) &&
                   (cfg_fm_width_i <= WW'(MAX_FM_WIDTH));
  assign lb_idx  = LBW'(col_q >> 1);
  assign lb_rd   = lb_q[lb_idx];

  // h_c: horizontal pair (held even pixel + current odd pixel).
  // p_c: h_c folded with the line-buffered pair of the row above.
  always_comb begin
    h_c = '0;
    p_c = '0;
`ifdef POOL_AVG_EN
    s_c = '0;
`endif
    for (int c = 0; c < CH_NUM; c++) begin
`ifdef POOL_AVG_EN
      if (mode_q) begin
        h_c[c] = {1'b0, hold_q[c]} + {1'b0, io.act_result_i[c]};
        s_c[c] = {1'b0, h_c[c]} + {1'b0, lb_rd[c]};
        p_c[c] = s_c[c][SW-1:2];
      end else begin
        h_c[c] = {1'b0, max2(hold_q[c], io.act_result_i[c])};
        p_c[c] = max2(h_c[c][DATA_WIDTH-1:0],
                      lb_rd[c][DATA_WIDTH-1:0]);
      end
`else
      h_c[c] = max2(hold_q[c], io.act_result_i[c]);
      p_c[c] = max2(h_c[c], lb_rd[c]);
`endif
    end
  end

  // Contents are don't-care after reset; every read is preceded by a
  // write from the even row of the same map.
  always_ff @(posedge clk) begin
    if (beat && col_odd && !row_q)
      lb_q[lb_idx] <= h_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q                  <= IDLE;
      width_q                  <= '0;
      col_q                    <= '0;
      row_q                    <= 1'b0;
      addr_q                   <= '0;
      hold_q                   <= '0;
      busy_o                   <= 1'b0;
      err_o                    <= 1'b0;
      io.pool_valid_o          <= 1'b0;
      io.pool_last_o           <= 1'b0;
      io.pool_result_o         <= '0;
      io.pool_result_address_o <= '0;
`ifdef POOL_AVG_EN
      mode_q                   <= 1'b0;
`endif
    end else begin
      err_o          <= 1'b0;
      io.pool_valid_o <= 1'b0;
      io.pool_last_o  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cfg_start_i) begin
            if (cfg_ok) begin
              width_q <= cfg_fm_width_i;
              addr_q  <= cfg_base_addr_i;
              col_q   <= '0;
              row_q   <= 1'b0;
              busy_o  <= 1'b1;
              state_q <= RUN;
`ifdef POOL_AVG_EN
              mode_q  <= cfg_mode_i;
`endif
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (io.act_valid_i) begin
            // Trailing even column of an odd-width row lands here
            // too, but is never paired.
            if (!col_odd)
              hold_q <= io.act_result_i;
            if (col_odd && row_q) begin
              io.pool_valid_o          <= 1'b1;
              io.pool_result_o         <= p_c;
              io.pool_result_address_o <= addr_q;
              addr_q                   <= addr_q + ADDRESS_WIDTH'(1);
            end
            if (row_end) begin
              col_q <= '0;
              row_q <= ~row_q;
            end else begin
              col_q <= col_q + WW'(1);
            end
            if (io.act_last_i) begin
              io.pool_last_o <= 1'b1;
              busy_o         <= 1'b0;
              state_q        <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_array_2x2.sv
// Self-checking bench for pool_array_2x2: directed and random maps
// compared against a window-level reference model.
module tb_pool_array_2x2;
  localparam int CH   = 16;
  localparam int DW   = 8;
  localparam int AW   = 10;
  localparam int MW   = 32;
  localparam int WW   = $clog2(MW+1);
  localparam int NMAX = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_start = 1'b0;
  logic [WW-1:0] cfg_w = '0;
  logic          cfg_mode = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic          busy;
  logic          err;

  pool_array_2x2_if #(
    .CH_NUM(CH), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)
  ) bus ();

  pool_array_2x2 #(
    .CH_NUM(CH), .DATA_WIDTH(DW),
    .ADDRESS_WIDTH(AW), .MAX_FM_WIDTH(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_start_i(cfg_start),
    .cfg_fm_width_i(cfg_w),
    .cfg_mode_i(cfg_mode),
    .cfg_base_addr_i(cfg_base),
    .busy_o(busy),
    .err_o(err),
    .io(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] img   [NMAX][CH];
  logic          exp_v [NMAX];
  logic          exp_l [NMAX];
  logic [DW-1:0] exp_d [NMAX][CH];
  logic [AW-1:0] exp_a [NMAX];
  logic          obs_v [NMAX];
  logic          obs_l [NMAX];
  logic          obs_b [NMAX];
  logic [DW-1:0] obs_d [NMAX][CH];
  logic [AW-1:0] obs_a [NMAX];
  logic          obs_busy_start;
  logic          obs_busy_end;
  int            spur;
  int            n_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < CH; c++)
        img[i][c] = DW'($urandom);
  endtask

  // Window-level model: beat i at (row i/w, col i%w) closes a window
  // when both are odd; the window is the 2x2 block ending there.
  task automatic model(input int w, input int n,
                       input bit mode, input int base);
    int k;
    bit avg;
    k = 0;
`ifdef POOL_AVG_EN
    avg = mode;
`else
    avg = 1'b0;
`endif
    for (int i = 0; i < n; i++) begin
      int r;
      int c;
      r = i / w;
      c = i % w;
      exp_l[i] = (i == n - 1);
      exp_v[i] = (r % 2 == 1) && (c % 2 == 1) && (c < 2 * (w / 2));
      exp_a[i] = '0;
      if (exp_v[i]) begin
        exp_a[i] = AW'((base + k) % (1 << AW));
        k++;
        for (int ch = 0; ch < CH; ch++) begin
          int p [4];
          int m;
          int s;
          p[0] = int'(img[i-w-1][ch]);
          p[1] = int'(img[i-w][ch]);
          p[2] = int'(img[i-1][ch]);
          p[3] = int'(img[i][ch]);
          m = 0;
          s = 0;
          for (int j = 0; j < 4; j++) begin
            s += p[j];
            if (p[j] > m) m = p[j];
          end
          exp_d[i][ch] = avg ? DW'(s / 4) : DW'(m);
        end
      end
    end
    n_out = k;
  endtask

  task automatic play_map(input int w, input int n, input bit mode,
                          input int base, input int gap_pct,
                          input bit start_on_last);
    cfg_w = WW'(w);
    cfg_mode = mode;
    cfg_base = AW'(base);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    obs_busy_start = busy;
    spur = 0;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        bus.act_valid_i = 1'b0;
        bus.act_last_i = 1'($urandom_range(1));
        for (int c = 0; c < CH; c++)
          bus.act_result_i[c] = DW'($urandom);
        tick();
        if (bus.pool_valid_o || bus.pool_last_o) spur++;
      end
      bus.act_valid_i = 1'b1;
      bus.act_last_i = (i == n - 1);
      for (int c = 0; c < CH; c++)
        bus.act_result_i[c] = img[i][c];
      cfg_start = start_on_last && (i == n - 1);
      tick();
      cfg_start = 1'b0;
      obs_v[i] = bus.pool_valid_o;
      obs_l[i] = bus.pool_last_o;
      obs_b[i] = busy;
      obs_a[i] = bus.pool_result_address_o;
      for (int c = 0; c < CH; c++)
        obs_d[i][c] = bus.pool_result_o[c];
      bus.act_valid_i = 1'b0;
      bus.act_last_i = 1'b0;
    end
    tick();
    obs_busy_end = busy;
    if (bus.pool_valid_o || bus.pool_last_o) spur++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 ||
        bus.pool_valid_o !== 1'b0 || bus.pool_last_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy/err/v/l=%b%b%b%b want 0000",
               busy, err, bus.pool_valid_o, bus.pool_last_o);
    end
    checks++;
    if (bus.pool_result_o !== '0 || bus.pool_result_address_o !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h want 0/0",
               bus.pool_result_o, bus.pool_result_address_o);
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_maps();
    for (int t = 0; t < 3; t++) begin
      int w;
      int n;
      int base;
      bit mode;
      int want [$];
      int got [$];
      want.delete();
      got.delete();
      case (t)
        0: begin
          w = 4; n = 16; mode = 1'b0; base = 'h010;
          fill_random(n);
          for (int i = 0; i < n; i++) img[i][0] = DW'(i);
          want = {5, 7, 13, 15};
        end
        1: begin
          w = 2; n = 4; mode = 1'b1; base = int'($urandom_range(1023));
          for (int i = 0; i < n; i++)
            for (int c = 0; c < CH; c++) img[i][c] = DW'(255 - i);
`ifdef POOL_AVG_EN
          want = {253};
`else
          want = {255};
`endif
        end
        default: begin
          w = 5; n = 10; mode = 1'b0; base = 0;
          fill_random(n);
          for (int i = 0; i < n; i++) img[i][0] = DW'(i + 1);
          want = {7, 9};
        end
      endcase
      model(w, n, mode, base);
      play_map(w, n, mode, base, 0, 1'b0);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (obs_v[i] !== exp_v[i] || obs_l[i] !== exp_l[i] ||
            obs_b[i] !== (i != n - 1)) begin
          errors++;
          $display("FAIL map%0d beat %0d v/l/busy got %b%b%b want %b%b%b",
                   t, i, obs_v[i], obs_l[i], obs_b[i],
                   exp_v[i], exp_l[i], (i != n - 1));
        end
        if (obs_v[i] === 1'b1) got.push_back(int'(obs_d[i][0]));
        if (exp_v[i]) begin
          checks++;
          if (obs_a[i] !== exp_a[i]) begin
            errors++;
            $display("FAIL map%0d addr beat %0d got %h want %h",
                     t, i, obs_a[i], exp_a[i]);
          end
          for (int c = 0; c < CH; c++) begin
            checks++;
            if (obs_d[i][c] !== exp_d[i][c]) begin
              errors++;
              $display("FAIL map%0d data beat %0d ch %0d got %0d want %0d",
                       t, i, c, obs_d[i][c], exp_d[i][c]);
            end
          end
        end
      end
      checks++;
      if (got != want) begin
        errors++;
        $display("FAIL map%0d ch0 seq got %p want %p", t, got, want);
      end
      checks++;
      if (spur !== 0 || obs_busy_start !== 1'b1 || obs_busy_end !== 1'b0) begin
        errors++;
        $display("FAIL map%0d framing spur=%0d busy %b/%b want 0 1/0",
                 t, spur, obs_busy_start, obs_busy_end);
      end
    end
  endtask

  task automatic test_early_last();
    fill_random(7);
    model(4, 7, 1'b0, 0);
    play_map(4, 7, 1'b0, 0, 0, 1'b0);
    checks++;
    if (obs_v[6] !== 1'b0 || obs_l[6] !== 1'b1) begin
      errors++;
      $display("FAIL early_last v/l got %b%b want 01", obs_v[6], obs_l[6]);
    end
    checks++;
    if (obs_v[5] !== 1'b1 || obs_d[5][0] !== exp_d[5][0]) begin
      errors++;
      $display("FAIL early_first v/d got %b/%0d want 1/%0d",
               obs_v[5], obs_d[5][0], exp_d[5][0]);
    end
    checks++;
    if (obs_busy_end !== 1'b0 || spur !== 0) begin
      errors++;
      $display("FAIL early_idle busy=%b spur=%0d want 0/0",
               obs_busy_end, spur);
    end
    fill_random(4);
    model(2, 4, 1'b0, 7);
    play_map(2, 4, 1'b0, 7, 0, 1'b0);
    checks++;
    if (obs_busy_start !== 1'b1 || obs_v[3] !== 1'b1 ||
        obs_d[3][CH-1] !== exp_d[3][CH-1] || obs_a[3] !== exp_a[3]) begin
      errors++;
      $display("FAIL early_restart busy/v/d/a got %b%b/%0d/%h want 11/%0d/%h",
               obs_busy_start, obs_v[3], obs_d[3][CH-1], obs_a[3],
               exp_d[3][CH-1], exp_a[3]);
    end
  endtask

  task automatic test_err_wrap();
    int bad [2];
    bad[0] = 1;
    bad[1] = 34;
    for (int k = 0; k < 2; k++) begin
      cfg_w = WW'(bad[k]);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL err_w%0d err/busy got %b%b want 10", bad[k], err, busy);
      end
      tick();
      checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL err_w%0d_after err/busy got %b%b want 00",
                 bad[k], err, busy);
      end
    end
    fill_random(8);
    model(4, 8, 1'b0, 'h3FF);
    play_map(4, 8, 1'b0, 'h3FF, 0, 1'b0);
    checks++;
    if (obs_v[5] !== 1'b1 || obs_a[5] !== 10'h3FF) begin
      errors++;
      $display("FAIL wrap_a0 v/a got %b/%h want 1/3ff", obs_v[5], obs_a[5]);
    end
    checks++;
    if (obs_v[7] !== 1'b1 || obs_a[7] !== 10'h000 ||
        obs_d[7][1] !== exp_d[7][1]) begin
      errors++;
      $display("FAIL wrap_a1 v/a/d got %b/%h/%0d want 1/000/%0d",
               obs_v[7], obs_a[7], obs_d[7][1], exp_d[7][1]);
    end
  endtask

  task automatic test_random();
    for (int m = 0; m < 8; m++) begin
      int w;
      int n;
      int base;
      bit mode;
      w = int'($urandom_range(2, MW));
      n = w * int'($urandom_range(2, 6));
      if ($urandom_range(3) == 0) n = int'($urandom_range(1, n));
      base = int'($urandom_range(1023));
      mode = 1'($urandom_range(1));
      fill_random(n);
      model(w, n, mode, base);
      play_map(w, n, mode, base, 30, 1'b0);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (obs_v[i] !== exp_v[i] || obs_l[i] !== exp_l[i]) begin
          errors++;
          $display("FAIL rnd%0d w%0d beat %0d v/l got %b%b want %b%b",
                   m, w, i, obs_v[i], obs_l[i], exp_v[i], exp_l[i]);
        end
        if (exp_v[i]) begin
          checks++;
          if (obs_a[i] !== exp_a[i]) begin
            errors++;
            $display("FAIL rnd%0d addr beat %0d got %h want %h",
                     m, i, obs_a[i], exp_a[i]);
          end
          for (int c = 0; c < CH; c++) begin
            checks++;
            if (obs_d[i][c] !== exp_d[i][c]) begin
              errors++;
              $display("FAIL rnd%0d data beat %0d ch %0d got %0d want %0d",
                       m, i, c, obs_d[i][c], exp_d[i][c]);
            end
          end
        end
      end
      checks++;
      if (spur !== 0 || obs_busy_end !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d gaps spur=%0d busy_end=%b want 0/0",
                 m, spur, obs_busy_end);
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_random(12);
    model(6, 12, 1'b0, 100);
    play_map(6, 12, 1'b0, 100, 0, 1'b1);
    checks++;
    if (obs_busy_end !== 1'b0 || obs_l[11] !== 1'b1 || obs_v[11] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ignore busy/l/v got %b%b%b want 011",
               obs_busy_end, obs_l[11], obs_v[11]);
    end
    checks++;
    if (obs_d[11][3] !== exp_d[11][3] || obs_a[11] !== exp_a[11]) begin
      errors++;
      $display("FAIL b2b_first d/a got %0d/%h want %0d/%h",
               obs_d[11][3], obs_a[11], exp_d[11][3], exp_a[11]);
    end
    fill_random(6);
    model(2, 6, 1'b1, 200);
    play_map(2, 6, 1'b1, 200, 0, 1'b0);
    checks++;
    if (obs_busy_start !== 1'b1 || obs_v[3] !== 1'b1 ||
        obs_d[3][2] !== exp_d[3][2] || obs_a[3] !== exp_a[3]) begin
      errors++;
      $display("FAIL b2b_second busy/v/d/a got %b%b/%0d/%h want 11/%0d/%h",
               obs_busy_start, obs_v[3], obs_d[3][2], obs_a[3],
               exp_d[3][2], exp_a[3]);
    end
  endtask

  task automatic test_reset_mid();
    fill_random(16);
    model(4, 16, 1'b0, 0);
    cfg_w = WW'(4);
    cfg_base = '0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.act_valid_i = 1'b1;
      bus.act_last_i = 1'b0;
      for (int c = 0; c < CH; c++) bus.act_result_i[c] = img[i][c];
      tick();
    end
    bus.act_valid_i = 1'b0;
    checks++;
    if (bus.pool_valid_o !== 1'b1 || bus.pool_result_o[0] !== exp_d[5][0]) begin
      errors++;
      $display("FAIL rstmid_pre v/d got %b/%0d want 1/%0d",
               bus.pool_valid_o, bus.pool_result_o[0], exp_d[5][0]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.pool_valid_o !== 1'b0 ||
        bus.pool_result_o !== '0 || bus.pool_result_address_o !== '0) begin
      errors++;
      $display("FAIL rstmid_clear busy/v got %b%b data %h addr %h want 0",
               busy, bus.pool_valid_o, bus.pool_result_o,
               bus.pool_result_address_o);
    end
    rst = 1'b1;
    spur = 0;
    for (int i = 0; i < 10; i++) begin
      bus.act_valid_i = 1'b1;
      bus.act_last_i = 1'(i == 9);
      for (int c = 0; c < CH; c++) bus.act_result_i[c] = DW'($urandom);
      tick();
      if (bus.pool_valid_o || bus.pool_last_o || busy) spur++;
    end
    bus.act_valid_i = 1'b0;
    bus.act_last_i = 1'b0;
    checks++;
    if (spur !== 0) begin
      errors++;
      $display("FAIL rstmid_idle spur got %0d want 0", spur);
    end
  endtask

  initial begin
    bus.act_valid_i = 1'b0;
    bus.act_last_i = 1'b0;
    bus.act_result_i = '0;
    test_reset();
    test_maps();
    test_early_last();
    test_err_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end
endmodule
